// File: rtl/alu_arb_pkg.sv
// Shared types for alu_arbiter: FSM state encoding, ALU opcode values and a
// small index-wrap helper used by the round-robin arbiter.
package alu_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_e;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_MUL = 4'd2;
    localparam logic [3:0] OP_DIV = 4'd3;
    localparam logic [3:0] OP_MOD = 4'd4;
    localparam logic [3:0] OP_AND = 4'd5;
    localparam logic [3:0] OP_OR  = 4'd6;
    localparam logic [3:0] OP_XOR = 4'd7;
    localparam logic [3:0] OP_NOT = 4'd8;
    localparam logic [3:0] OP_SHL = 4'd9;
    localparam logic [3:0] OP_SHR = 4'd10;
    localparam logic [3:0] OP_ROL = 4'd11;
    localparam logic [3:0] OP_ROR = 4'd12;
    localparam logic [3:0] OP_LT  = 4'd13;
    localparam logic [3:0] OP_GT  = 4'd14;
    localparam logic [3:0] OP_EQ  = 4'd15;

    // Offsets are always below 2*n, so a single subtraction is enough.
    function automatic int rr_wrap(input int idx, input int n);
        return (idx >= n) ? (idx - n) : idx;
    endfunction

endpackage

// File: rtl/alu_arbiter_rr.sv
// Combinational round-robin arbiter: grants the first requester at or after
// ptr (wrapping), producing a one-hot grant and its index.
module rr_arbiter
    import alu_arb_pkg::*;
#(
    parameter int N    = 4,
    parameter int ID_W = $clog2(N)
) (
    input  logic [N-1:0]    req,
    input  logic [ID_W-1:0] ptr,
    input  logic            en,
    output logic [N-1:0]    gnt,
    output logic [ID_W-1:0] gnt_idx
);

    int   cand_s;
    logic found_s;
    logic hit_s;

    // Scan from ptr upward; the first hit wins and masks all later candidates.
    always_comb begin
        gnt     = {N{1'b0}};
        gnt_idx = {ID_W{1'b0}};
        found_s = 1'b0;
        hit_s   = 1'b0;
        cand_s  = 0;
        for (int i = 0; i < N; i++) begin
            cand_s       = rr_wrap(int'(ptr) + i, N);
            hit_s        = en & ~found_s & req[cand_s];
            gnt[cand_s]  = gnt[cand_s] | hit_s;
            gnt_idx      = hit_s ? ID_W'(cand_s) : gnt_idx;
            found_s      = found_s | hit_s;
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one external 8-bit ALU among N_REQ requesters (IDLE->EXEC->RESP).
// Optional macro ALU_ARBITER_STATS_EN adds stat_ops / stat_stall counters.
module alu_arbiter
    import alu_arb_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int ID_W  = $clog2(N_REQ)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N_REQ-1:0]     req_valid,
    output logic [N_REQ-1:0]     req_ready,
    input  logic [4*N_REQ-1:0]   req_opcode,
    input  logic [8*N_REQ-1:0]   req_a,
    input  logic [8*N_REQ-1:0]   req_b,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [ID_W-1:0]      rsp_id,
    output logic [15:0]          rsp_data,
    output logic                 rsp_cout,
    output logic                 rsp_bout,
    output logic [3:0]           alu_opcode,
    output logic [7:0]           alu_a,
    output logic [7:0]           alu_b,
    input  logic [15:0]          alu_result,
    input  logic                 alu_cout,
    input  logic                 alu_bout
`ifdef ALU_ARBITER_STATS_EN
    ,
    output logic [31:0]          stat_ops,
    output logic [31:0]          stat_stall
`endif
);

    state_e            state_r;
    state_e            state_nxt_s;
    logic [ID_W-1:0]   rr_ptr_r;
    logic [ID_W-1:0]   id_r;
    logic [N_REQ-1:0]  gnt_s;
    logic [ID_W-1:0]   gnt_idx_s;
    logic              arb_en_s;
    logic              accept_s;

    // Grants are only offered in IDLE and never while reset is asserted.
    assign arb_en_s  = (state_r == IDLE) & rst_n;
    assign req_ready = gnt_s;

    rr_arbiter #(
        .N    (N_REQ),
        .ID_W (ID_W)
    ) u_rr_arbiter (
        .req     (req_valid),
        .ptr     (rr_ptr_r),
        .en      (arb_en_s),
        .gnt     (gnt_s),
        .gnt_idx (gnt_idx_s)
    );

    // Next-state logic; accept_s marks the request handshake cycle.
    always_comb begin
        state_nxt_s = state_r;
        accept_s    = 1'b0;
        case (state_r)
            IDLE: begin
                if (|gnt_s) begin
                    state_nxt_s = EXEC;
                    accept_s    = 1'b1;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            EXEC: state_nxt_s = RESP;
            RESP: begin
                if (rsp_ready) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = RESP;
                end
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // FSM state, round-robin pointer and tag of the op in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= IDLE;
            rr_ptr_r <= {ID_W{1'b0}};
            id_r     <= {ID_W{1'b0}};
        end else begin
            state_r <= state_nxt_s;
            if (accept_s) begin
                id_r     <= gnt_idx_s;
                rr_ptr_r <= (gnt_idx_s == ID_W'(N_REQ - 1)) ? {ID_W{1'b0}}
                                                             : gnt_idx_s + ID_W'(1);
            end else begin
                id_r     <= id_r;
                rr_ptr_r <= rr_ptr_r;
            end
        end
    end

    // ALU operand registers keep their last value between ops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_opcode <= 4'd0;
            alu_a      <= 8'd0;
            alu_b      <= 8'd0;
        end else if (accept_s) begin
            alu_opcode <= req_opcode[{gnt_idx_s, 2'b00} +: 4];
            alu_a      <= req_a[{gnt_idx_s, 3'b000} +: 8];
            alu_b      <= req_b[{gnt_idx_s, 3'b000} +: 8];
        end else begin
            alu_opcode <= alu_opcode;
            alu_a      <= alu_a;
            alu_b      <= alu_b;
        end
    end

    // Response capture in EXEC; held stable in RESP until the consumer accepts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid <= 1'b0;
            rsp_id    <= {ID_W{1'b0}};
            rsp_data  <= 16'd0;
            rsp_cout  <= 1'b0;
            rsp_bout  <= 1'b0;
        end else begin
            case (state_r)
                EXEC: begin
                    rsp_valid <= 1'b1;
                    rsp_id    <= id_r;
                    rsp_data  <= alu_result;
                    rsp_cout  <= alu_cout;
                    rsp_bout  <= alu_bout;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                    end else begin
                        rsp_valid <= rsp_valid;
                    end
                end
                default: rsp_valid <= rsp_valid;
            endcase
        end
    end

`ifdef ALU_ARBITER_STATS_EN
    logic rsp_hs_s;
    logic rsp_stall_s;

    assign rsp_hs_s    = rsp_valid & rsp_ready;
    assign rsp_stall_s = rsp_valid & ~rsp_ready;

    // Free-running wrap-around counters of completed ops and stalled cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_ops   <= 32'd0;
            stat_stall <= 32'd0;
        end else begin
            stat_ops   <= rsp_hs_s    ? stat_ops + 32'd1   : stat_ops;
            stat_stall <= rsp_stall_s ? stat_stall + 32'd1 : stat_stall;
        end
    end
`endif

endmodule
